// File: rtl/audio_sfx_pkg.sv
// Shared constants for the pong sound-effect scheduler: effect indices,
// FSM state encodings, default tone half-periods and durations.
package audio_sfx_pkg;

    localparam logic [1:0] SFX_PADDLE = 2'd0;
    localparam logic [1:0] SFX_WALL   = 2'd1;
    localparam logic [1:0] SFX_SCORE  = 2'd2;

    typedef logic [1:0] sfx_state_t;

    localparam sfx_state_t ST_IDLE = 2'd0;
    localparam sfx_state_t ST_LOAD = 2'd1;
    localparam sfx_state_t ST_PLAY = 2'd2;
    localparam sfx_state_t ST_GAP  = 2'd3;

    // Half-periods in clk cycles at 25 MHz: 440 Hz, 220 Hz, 880 Hz.
    localparam int HP_PADDLE = 28409;
    localparam int HP_WALL   = 56818;
    localparam int HP_SCORE  = 14205;

    // Effect durations in ms ticks.
    localparam int DUR_PADDLE = 50;
    localparam int DUR_WALL   = 30;
    localparam int DUR_SCORE  = 300;

    // Fixed priority: score > wall > paddle.
    function automatic logic [1:0] sfx_pick(input logic [2:0] p);
        if (p[2])      return SFX_SCORE;
        else if (p[1]) return SFX_WALL;
        else           return SFX_PADDLE;
    endfunction

endpackage

// File: rtl/audio_square_gen.sv
// Square-wave tone generator: toggles wave every half_period cycles while en.
// Ports: clk, reset_n (sync, active-low), en, load (restart), half_period, wave.
module audio_square_gen #(
    parameter int PERIOD_W = 17
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                load,
    input  logic [PERIOD_W-1:0] half_period,
    output logic                wave
);

    logic [PERIOD_W-1:0] cnt;
    logic                tog;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
            tog <= 1'b0;
        end else if (load || !en) begin
            cnt <= '0;
            tog <= 1'b0;
        end else if (cnt == half_period - PERIOD_W'(1)) begin
            cnt <= '0;
            tog <= ~tog;
        end else begin
            cnt <= cnt + PERIOD_W'(1);
        end
    end

    // Gated so the pin drops the same cycle the tone is disabled.
    assign wave = tog & en;

endmodule

// File: rtl/audio_sfx_scheduler.sv
// Latches pong sound requests, grants by fixed priority and plays each tone
// for a fixed duration followed by a silence gap. Ports: clk, reset_n, req,
// grant, busy, tone_half_period, speaker; mute when AUDIO_SFX_MUTE_EN defined.
module audio_sfx_scheduler
    import audio_sfx_pkg::*;
#(
    parameter int TICK_DIV = 25000,
    parameter int PERIOD_W = 17,
    parameter int DUR_W    = 10,
    parameter int GAP_MS   = 10,
    parameter int HP0      = HP_PADDLE,
    parameter int HP1      = HP_WALL,
    parameter int HP2      = HP_SCORE,
    parameter int DUR0     = DUR_PADDLE,
    parameter int DUR1     = DUR_WALL,
    parameter int DUR2     = DUR_SCORE
) (
    input  logic                clk,
    input  logic                reset_n,
`ifdef AUDIO_SFX_MUTE_EN
    input  logic                mute,
`endif
    input  logic [2:0]          req,
    output logic [2:0]          grant,
    output logic                busy,
    output logic [PERIOD_W-1:0] tone_half_period,
    output logic                speaker
);

    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_LIM = (GAP_MS > 0) ? GAP_MS : 1;

    // A zero duration still plays for one tick.
    localparam int DL0 = (DUR0 > 0) ? DUR0 - 1 : 0;
    localparam int DL1 = (DUR1 > 0) ? DUR1 - 1 : 0;
    localparam int DL2 = (DUR2 > 0) ? DUR2 - 1 : 0;

    sfx_state_t          state;
    logic [2:0]          pending;
    logic [1:0]          sel;
    logic [TICK_W-1:0]   tick;
    logic [DUR_W-1:0]    dur_cnt;

    logic [1:0]          pick;
    logic [2:0]          pick_oh;
    logic [PERIOD_W-1:0] pick_hp;
    logic [DUR_W-1:0]    dur_last;
    logic [2:0]          clr;
    logic                tick_wrap;
    logic                preempt;
    logic                gen_en;
    logic                wave;

    always_comb begin
        pick    = sfx_pick(pending);
        pick_oh = 3'b001 << pick;

        pick_hp = PERIOD_W'(HP0);
        case (pick)
            SFX_WALL:  pick_hp = PERIOD_W'(HP1);
            SFX_SCORE: pick_hp = PERIOD_W'(HP2);
            default:   pick_hp = PERIOD_W'(HP0);
        endcase

        dur_last = DUR_W'(DL0);
        preempt  = 1'b0;
        case (sel)
            SFX_WALL: begin
                dur_last = DUR_W'(DL1);
                preempt  = pending[2];
            end
            SFX_SCORE: begin
                dur_last = DUR_W'(DL2);
                preempt  = 1'b0;
            end
            default: begin
                dur_last = DUR_W'(DL0);
                preempt  = |pending[2:1];
            end
        endcase

        clr       = (state == ST_LOAD) ? pick_oh : 3'b000;
        tick_wrap = (tick == TICK_W'(TICK_DIV - 1));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            pending          <= '0;
            sel              <= SFX_PADDLE;
            grant            <= '0;
            tone_half_period <= '0;
            tick             <= '0;
            dur_cnt          <= '0;
        end else begin
            // A request landing on its own clear cycle survives (set wins).
            pending <= (pending & ~clr) | req;

            unique case (state)
                ST_IDLE: begin
                    if (|pending) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    sel              <= pick;
                    grant            <= pick_oh;
                    tone_half_period <= pick_hp;
                    tick             <= '0;
                    dur_cnt          <= '0;
                    state            <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (preempt) begin
                        state <= ST_LOAD;
                    end else if (tick_wrap) begin
                        tick <= '0;
                        if (dur_cnt == dur_last) begin
                            dur_cnt <= '0;
                            grant   <= '0;
                            state   <= ST_GAP;
                        end else begin
                            dur_cnt <= dur_cnt + DUR_W'(1);
                        end
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                ST_GAP: begin
                    if (tick_wrap) begin
                        tick <= '0;
                        if (dur_cnt == DUR_W'(GAP_LIM - 1)) begin
                            dur_cnt <= '0;
                            state   <= ST_IDLE;
                        end else begin
                            dur_cnt <= dur_cnt + DUR_W'(1);
                        end
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy   = (state != ST_IDLE);
    assign gen_en = (state == ST_PLAY) && (tone_half_period != '0);

    audio_square_gen #(
        .PERIOD_W (PERIOD_W)
    ) u_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (gen_en),
        .load        (state == ST_LOAD),
        .half_period (tone_half_period),
        .wave        (wave)
    );

`ifdef AUDIO_SFX_MUTE_EN
    assign speaker = wave & ~mute;
`else
    assign speaker = wave;
`endif

endmodule

// File: tb/tb_audio_sfx_scheduler.sv
// Directed bench for audio_sfx_scheduler with TICK_DIV=10.
// A second instance (HP0=4, DUR2=0) covers the square wave and zero duration.
module tb_audio_sfx_scheduler;
    import audio_sfx_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  req, req_sq;
    logic [2:0]  grant, sq_grant;
    logic        busy, sq_busy;
    logic [16:0] thp, sq_thp;
    logic        spk, sq_spk;
`ifdef AUDIO_SFX_MUTE_EN
    logic        mute_main;
    logic        mute_sq;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    audio_sfx_scheduler #(.TICK_DIV(10)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
`ifdef AUDIO_SFX_MUTE_EN
        .mute             (mute_main),
`endif
        .req              (req),
        .grant            (grant),
        .busy             (busy),
        .tone_half_period (thp),
        .speaker          (spk)
    );

    audio_sfx_scheduler #(.TICK_DIV(10), .HP0(4), .DUR2(0)) dut_sq (
        .clk              (clk),
        .reset_n          (reset_n),
`ifdef AUDIO_SFX_MUTE_EN
        .mute             (mute_sq),
`endif
        .req              (req_sq),
        .grant            (sq_grant),
        .busy             (sq_busy),
        .tone_half_period (sq_thp),
        .speaker          (sq_spk)
    );

    typedef struct {
        logic [2:0] req;
        logic [2:0] g1;
        int         hp1;
        int         busy1;
        logic [2:0] g2;
    } vec_t;

    vec_t vt[6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [2:0] r);
        req = r;
        cyc(1);
        req = 3'b000;
    endtask

    task automatic count_busy(input bit sq, output int n);
        n = 0;
        while ((sq ? sq_busy : busy) && n < 20000) begin
            n++;
            cyc(1);
        end
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        int quiet = 0;
        while (quiet < 3 && k < 20000) begin
            if (!busy) quiet++;
            else quiet = 0;
            cyc(1);
            k++;
        end
        if (k >= 20000) check(name, 32'd1, 32'd0);
    endtask

    task automatic sq_run(input logic m);
        int werr = 0;
        int gerr = 0;
        int perr = 0;
        logic exp;
`ifdef AUDIO_SFX_MUTE_EN
        mute_sq = m;
`endif
        req_sq = 3'b001;
        cyc(1);
        req_sq = 3'b000;
        cyc(2);
        check("sq_grant_first", sq_grant, 3'b001);
        for (int k = 0; k < 500; k++) begin
            exp = m ? 1'b0 : 1'(((k / 4) % 2));
            if (sq_spk !== exp) werr++;
            if (sq_grant !== 3'b001) gerr++;
            cyc(1);
        end
        for (int k = 0; k < 100; k++) begin
            if (sq_spk !== 1'b0 || sq_grant !== 3'b000 || sq_busy !== 1'b1)
                perr++;
            cyc(1);
        end
        check(m ? "sq_mute_wave" : "sq_play_wave", werr, 0);
        check("sq_play_grant", gerr, 0);
        check("sq_gap_silent", perr, 0);
        check("sq_idle_after_gap", sq_busy, 1'b0);
        cyc(3);
`ifdef AUDIO_SFX_MUTE_EN
        mute_sq = 1'b0;
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;

        vt[0] = '{3'b001, 3'b001, 28409, 601,  3'b000};
        vt[1] = '{3'b010, 3'b010, 56818, 401,  3'b000};
        vt[2] = '{3'b100, 3'b100, 14205, 3101, 3'b000};
        vt[3] = '{3'b011, 3'b010, 56818, 401,  3'b001};
        vt[4] = '{3'b111, 3'b100, 14205, 3101, 3'b010};
        vt[5] = '{3'b110, 3'b100, 14205, 3101, 3'b010};

`ifdef AUDIO_SFX_MUTE_EN
        mute_main = 1'b0;
        mute_sq   = 1'b0;
`endif
        reset_n = 1'b0;
        req     = 3'b111;
        req_sq  = 3'b111;
        cyc(3);
        check("rst_grant", grant, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_speaker", spk, 1'b0);
        check("rst_half_period", thp, 17'd0);
        reset_n = 1'b1;
        req     = 3'b000;
        req_sq  = 3'b000;
        cyc(10);
        check("rst_nothing_plays", busy, 1'b0);
        check("rst_nothing_sq", sq_busy, 1'b0);

        for (int i = 0; i < 6; i++) begin
            pulse(vt[i].req);
            cyc(1);
            check("vec_load_busy", busy, 1'b1);
            check("vec_load_no_grant", grant, 3'b000);
            cyc(1);
            check("vec_grant", grant, vt[i].g1);
            check("vec_half_period", thp, vt[i].hp1);
            count_busy(1'b0, n);
            check("vec_busy_len", n + 1, vt[i].busy1);
            cyc(2);
            check("vec_next_grant", grant, vt[i].g2);
            wait_idle("vec_drain_timeout");
        end

        // Score preempts paddle 100 cycles into PLAY with no gap.
        pulse(3'b001);
        cyc(2);
        check("pre_paddle_grant", grant, 3'b001);
        cyc(100);
        pulse(3'b100);
        cyc(1);
        check("pre_load_busy", busy, 1'b1);
        check("pre_load_no_gap", grant, 3'b001);
        cyc(1);
        check("pre_score_grant", grant, 3'b100);
        check("pre_score_hp", thp, 17'd14205);
        count_busy(1'b0, n);
        check("pre_score_len", n, 3100);
        cyc(5);
        check("pre_no_resume", busy, 1'b0);

        // Paddle re-requested during its own PLAY replays after the gap.
        pulse(3'b001);
        cyc(2);
        check("rereq_first", grant, 3'b001);
        cyc(50);
        pulse(3'b001);
        count_busy(1'b0, n);
        cyc(2);
        check("rereq_replay", grant, 3'b001);
        wait_idle("rereq_drain_timeout");

        // req held across the LOAD that clears it: set wins, replay follows.
        req = 3'b001;
        cyc(3);
        req = 3'b000;
        check("hold_grant", grant, 3'b001);
        count_busy(1'b0, n);
        cyc(2);
        check("hold_replay", grant, 3'b001);
        wait_idle("hold_drain_timeout");

        // Reset mid-effect discards everything.
        pulse(3'b011);
        cyc(50);
        reset_n = 1'b0;
        cyc(1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_grant", grant, 3'b000);
        check("midrst_hp", thp, 17'd0);
        reset_n = 1'b1;
        cyc(6);
        check("midrst_pending_gone", busy, 1'b0);

        // Square wave with half-period 4.
        sq_run(1'b0);
`ifdef AUDIO_SFX_MUTE_EN
        sq_run(1'b1);
`endif

        // DUR=0 plays one tick: LOAD + 10 PLAY + 100 GAP.
        req_sq = 3'b100;
        cyc(1);
        req_sq = 3'b000;
        cyc(1);
        k = 0;
        count_busy(1'b1, k);
        check("dur0_busy_len", k, 111);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
